// File: rtl/tone_synth.sv
// tone_synth: phase-accumulator square-wave tone generator (iEnable/iFreq in; oWave, signed oSample, oActive out)
module tone_synth #(
   parameter int CLK_HZ    = 50000000,
   parameter int AMPLITUDE = 8192,
   parameter int ACC_WIDTH = 32
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic        iEnable,
   input  logic [15:0] iFreq,
   output logic        oWave,
   output logic [15:0] oSample,
   output logic        oActive
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   localparam logic [ACC_WIDTH-1:0] lim = ACC_WIDTH'(CLK_HZ);
   localparam logic [15:0] amp_p = 16'(AMPLITUDE);
   localparam logic [15:0] amp_n = 16'(-AMPLITUDE);
   state_t state, state_n;
   logic [ACC_WIDTH-1:0] acc, acc_n, sum;
   logic [15:0] freq_lat, freq_n, pending, sample_n;
   logic req, tog, wave_n, active_n;
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state    <= IDLE;
         acc      <= '0;
         freq_lat <= '0;
         pending  <= '0;
         oWave    <= 1'b0;
         oSample  <= '0;
         oActive  <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         freq_lat <= freq_n;
         pending  <= req ? iFreq : pending;
         oWave    <= wave_n;
         oSample  <= sample_n;
         oActive  <= active_n;
      end
   end
   always_comb begin
      req     = iEnable && (iFreq != 16'd0);
      sum     = acc + ACC_WIDTH'({freq_lat, 1'b0});
      tog     = sum >= lim;
      state_n = state;
      acc_n   = acc;
      freq_n  = freq_lat;
      wave_n  = oWave;
      if (state == IDLE) begin
         state_n = req ? RUN : IDLE;
         wave_n  = req;
         acc_n   = '0;
         freq_n  = req ? iFreq : freq_lat;
      end else if (state == RUN && !req && !oWave) begin
         state_n = IDLE;
         acc_n   = '0;
      end else begin
         acc_n   = tog ? sum - lim : sum;
         wave_n  = oWave ^ tog;
         freq_n  = tog ? pending : freq_lat;
         state_n = req ? RUN : (tog ? IDLE : DRAIN);
         acc_n   = (state_n == IDLE) ? '0 : acc_n;
      end
   end
   always_comb begin
      active_n = state_n != IDLE;
      sample_n = !active_n ? 16'd0 : (wave_n ? amp_p : amp_n);
   end
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed self-checking bench for tone_synth at CLK_HZ=1000, AMPLITUDE=100
module tb_tone_synth;
   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iEnable = 1'b1;
   logic [15:0] iFreq = 16'd50;
   logic        oWave, oActive;
   logic [15:0] oSample;
   int errors = 0;
   int checks = 0;
   tone_synth #(.CLK_HZ(1000), .AMPLITUDE(100), .ACC_WIDTH(32)) dut (
      .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iFreq(iFreq),
      .oWave(oWave), .oSample(oSample), .oActive(oActive)
   );
   always #5 iClock = ~iClock;
   task automatic tick();
      @(posedge iClock);
      #1;
   endtask
   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic outs(input string tag, input logic w, input logic a);
      check({tag, " wave"}, {31'd0, oWave}, {31'd0, w});
      check({tag, " active"}, {31'd0, oActive}, {31'd0, a});
      check({tag, " sample"}, 32'($signed(oSample)), !a ? 0 : (w ? 100 : -100));
   endtask
   task automatic half(input string tag, input logic level, input int already, input int len);
      int n;
      n = already;
      check({tag, " level"}, {31'd0, oWave}, {31'd0, level});
      do begin
         tick();
         n++;
      end while (oWave === level && n < 100);
      check({tag, " len"}, n, len);
   endtask
   initial begin
      tick();
      outs("rst0", 0, 0);
      tick();
      outs("rst1", 0, 0);
      iReset = 1'b0;
      tick();
      outs("start", 1, 1);
      half("hi1", 1, 0, 10);
      outs("lo1", 0, 1);
      half("lo1", 0, 0, 10);
      half("hi2", 1, 0, 10);
      half("lo2", 0, 0, 10);
      repeat (3) tick();
      iFreq = 16'd25;
      half("fc_hi", 1, 3, 10);
      half("fc_lo", 0, 0, 20);
      half("fc_hi2", 1, 0, 20);
      iFreq = 16'd50;
      half("fc_lo2", 0, 0, 20);
      repeat (2) tick();
      iEnable = 1'b0;
      tick();
      outs("drain", 1, 1);
      half("stop_hi", 1, 3, 10);
      outs("stop", 0, 0);
      tick();
      outs("stop_idle", 0, 0);
      iEnable = 1'b1;
      tick();
      outs("go", 1, 1);
      half("sl_hi", 1, 0, 10);
      repeat (2) tick();
      iFreq = 16'd0;
      tick();
      outs("sl_idle", 0, 0);
      repeat (5) tick();
      outs("f0_idle", 0, 0);
      iFreq = 16'd50;
      tick();
      outs("re", 1, 1);
      repeat (2) tick();
      iEnable = 1'b0;
      repeat (2) tick();
      outs("re_drain", 1, 1);
      iEnable = 1'b1;
      half("re_hi", 1, 4, 10);
      half("re_lo", 0, 0, 10);
      half("re_hi2", 1, 0, 10);
      half("re_lo2", 0, 0, 10);
      repeat (3) tick();
      iReset = 1'b1;
      tick();
      outs("rst_mid", 0, 0);
      iReset = 1'b0;
      iEnable = 1'b0;
      tick();
      outs("post", 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
